// File: rtl/mem_led_top_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_led_top_if
// Brief    : Memory/LED bus bundle for mem_led_top (read/write strobes,
//            word address, byte select and displayed byte).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_led_top_if #(
  parameter int ADDR_W = 6
);
  logic              Mem_Read;
  logic              Mem_Write;
  logic [ADDR_W+1:2] Mem_Addr;
  logic [1:0]        MUX;
  logic [7:0]        LED;

  modport master (
    output Mem_Read,
    output Mem_Write,
    output Mem_Addr,
    output MUX,
    input  LED
  );

  modport slave (
    input  Mem_Read,
    input  Mem_Write,
    input  Mem_Addr,
    input  MUX,
    output LED
  );
endinterface
`default_nettype wire

// File: rtl/mem_led_top.sv
`default_nettype none
// ============================================================================
// Module   : mem_led_top
// Brief    : 64x32 register-file memory with address-indexed write pattern
//            generator and byte selector driving 8 LEDs.
//            Optional macro LED_REG_EN registers the LED output (1-cycle
//            read latency); default build is purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module mem_led_top #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  wire logic     Clk,
  input  wire logic     Reset,
  mem_led_top_if.slave  bus
);

  localparam int c_depth = 2 ** ADDR_W;

  localparam logic [DATA_W-1:0] c_pat0 = 32'h0000_000F;
  localparam logic [DATA_W-1:0] c_pat1 = 32'h0000_0DB0;
  localparam logic [DATA_W-1:0] c_pat2 = 32'hFF3C_C381;
  localparam logic [DATA_W-1:0] c_pat3 = 32'h1234_5678;

  logic [DATA_W-1:0] r_mem [c_depth];
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rword;
  logic [7:0]        w_led;

  // Write data depends only on the low two word-address bits.
  always_comb begin
    w_wdata = c_pat0;
    case (bus.Mem_Addr[3:2])
      2'd0:    w_wdata = c_pat0;
      2'd1:    w_wdata = c_pat1;
      2'd2:    w_wdata = c_pat2;
      default: w_wdata = c_pat3;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < c_depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.Mem_Write) begin
      r_mem[bus.Mem_Addr] <= w_wdata;
    end
  end

  // Read path sees stored contents only; a same-cycle write is not bypassed.
  assign w_rword = r_mem[bus.Mem_Addr];

  always_comb begin
    w_led = 8'h00;
    if (bus.Mem_Read) begin
      case (bus.MUX)
        2'd0:    w_led = w_rword[7:0];
        2'd1:    w_led = w_rword[15:8];
        2'd2:    w_led = w_rword[23:16];
        default: w_led = w_rword[31:24];
      endcase
    end
  end

`ifdef LED_REG_EN
  logic [7:0] r_led;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_led <= 8'h00;
    end else begin
      r_led <= w_led;
    end
  end

  assign bus.LED = r_led;
`else
  assign bus.LED = w_led;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_led_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_led_top
// Brief    : Directed, table-driven self-checking bench for mem_led_top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_led_top;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [5:0] addr;
    logic [1:0] mux;
    logic [7:0] exp;
  } vec_t;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  mem_led_top_if #(.ADDR_W(6)) bus ();

  mem_led_top #(
    .ADDR_W(6),
    .DATA_W(32)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: LED=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Let the read value settle (one edge later in the registered build).
  task automatic settle();
`ifdef LED_REG_EN
    @(posedge Clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge Clk);
    bus.Mem_Addr  = v.addr;
    bus.MUX       = v.mux;
    bus.Mem_Read  = v.rd;
    bus.Mem_Write = v.wr;
    if (v.wr) begin
      @(posedge Clk);
      #1;
      bus.Mem_Write = 1'b0;
    end
    settle();
    check(name, bus.LED, v.exp);
  endtask

  vec_t vecs [15];

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{wr:1'b1, rd:1'b1, addr:6'd0,  mux:2'd0, exp:8'h0F};
    vecs[1]  = '{wr:1'b0, rd:1'b1, addr:6'd0,  mux:2'd1, exp:8'h00};
    vecs[2]  = '{wr:1'b1, rd:1'b1, addr:6'd1,  mux:2'd0, exp:8'hB0};
    vecs[3]  = '{wr:1'b0, rd:1'b1, addr:6'd1,  mux:2'd1, exp:8'h0D};
    vecs[4]  = '{wr:1'b0, rd:1'b1, addr:6'd1,  mux:2'd2, exp:8'h00};
    vecs[5]  = '{wr:1'b1, rd:1'b1, addr:6'd2,  mux:2'd0, exp:8'h81};
    vecs[6]  = '{wr:1'b0, rd:1'b1, addr:6'd2,  mux:2'd1, exp:8'hC3};
    vecs[7]  = '{wr:1'b0, rd:1'b1, addr:6'd2,  mux:2'd2, exp:8'h3C};
    vecs[8]  = '{wr:1'b0, rd:1'b1, addr:6'd2,  mux:2'd3, exp:8'hFF};
    vecs[9]  = '{wr:1'b0, rd:1'b0, addr:6'd2,  mux:2'd3, exp:8'h00};
    vecs[10] = '{wr:1'b1, rd:1'b1, addr:6'd5,  mux:2'd0, exp:8'hB0};
    vecs[11] = '{wr:1'b1, rd:1'b1, addr:6'd63, mux:2'd0, exp:8'h78};
    vecs[12] = '{wr:1'b0, rd:1'b1, addr:6'd63, mux:2'd2, exp:8'h34};
    vecs[13] = '{wr:1'b0, rd:1'b1, addr:6'd10, mux:2'd3, exp:8'h00};
    vecs[14] = '{wr:1'b1, rd:1'b1, addr:6'd3,  mux:2'd3, exp:8'h12};

    bus.Mem_Read  = 1'b0;
    bus.Mem_Write = 1'b0;
    bus.Mem_Addr  = '0;
    bus.MUX       = 2'd0;
    Reset         = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_led", bus.LED, 8'h00);
    @(negedge Clk);
    Reset = 1'b1;

    // Freshly reset memory reads zero at every byte of the first words.
    for (int a = 0; a < 4; a++) begin
      for (int m = 0; m < 4; m++) begin
        vec_t v;
        v = '{wr:1'b0, rd:1'b1, addr:6'(a), mux:2'(m), exp:8'h00};
        apply(v, $sformatf("reset_rd_a%0d_m%0d", a, m));
      end
    end

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle while addr 3 is being displayed.
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check("async_reset_led", bus.LED, 8'h00);
    @(negedge Clk);
    Reset = 1'b1;
    apply('{wr:1'b0, rd:1'b1, addr:6'd3, mux:2'd3, exp:8'h00}, "post_reset_a3");
    apply('{wr:1'b0, rd:1'b1, addr:6'd63, mux:2'd0, exp:8'h00}, "post_reset_a63");

    // Reset wins over a concurrent write.
    @(negedge Clk);
    Reset         = 1'b0;
    bus.Mem_Addr  = 6'd7;
    bus.Mem_Write = 1'b1;
    @(posedge Clk);
    #1;
    bus.Mem_Write = 1'b0;
    Reset         = 1'b1;
    apply('{wr:1'b0, rd:1'b1, addr:6'd7, mux:2'd0, exp:8'h00}, "reset_over_write");

    // Simultaneous read and write on fresh addr 6: old value, then new.
    @(negedge Clk);
    bus.Mem_Addr  = 6'd6;
    bus.MUX       = 2'd0;
    bus.Mem_Read  = 1'b1;
    bus.Mem_Write = 1'b1;
`ifdef LED_REG_EN
    @(posedge Clk);
    #1;
    bus.Mem_Write = 1'b0;
    check("rw_before", bus.LED, 8'h00);
    @(posedge Clk);
    #1;
    check("rw_after", bus.LED, 8'h81);
`else
    #1;
    check("rw_before", bus.LED, 8'h00);
    @(posedge Clk);
    #1;
    bus.Mem_Write = 1'b0;
    check("rw_after", bus.LED, 8'h81);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
